// File: rtl/sc_io_port.sv
// rtl/sc_io_port.sv - memory-mapped I/O port block: output latches, synchronized inputs, edge flags, cycle counter.
// Eight-word window at IO_BASE; reads are zero-wait combinational, writes land on the rising edge.
module sc_io_port #(
  parameter logic [31:0] IO_BASE     = 32'h00000080,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic        we,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  output logic [31:0] dataout,
  output logic        io_hit,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);

  localparam logic [2:0] R_OUT0 = 3'd0;
  localparam logic [2:0] R_OUT1 = 3'd1;
  localparam logic [2:0] R_OUT2 = 3'd2;
  localparam logic [2:0] R_IN0  = 3'd3;
  localparam logic [2:0] R_IN1  = 3'd4;
  localparam logic [2:0] R_EDGE = 3'd5;
  localparam logic [2:0] R_CNT  = 3'd6;
  localparam logic [2:0] R_CTRL = 3'd7;

  logic [31:0] out0_q, out1_q, out2_q;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  edge_q, edge_d, edge_set, edge_clr;
  logic [1:0]  prev_q;
  logic        cnt_en_q, cnt_clr_q;
  logic [SYNC_STAGES-1:0][31:0] sync0_q, sync1_q;

  logic [2:0]  sel;
  logic        wr_en;
  logic [31:0] in0, in1;
  logic        unused_addr;

  assign io_hit      = (addr[31:5] == IO_BASE[31:5]);
  assign sel         = addr[4:2];
  assign wr_en       = we & io_hit;
  assign unused_addr = ^addr[1:0];

  assign in0 = sync0_q[SYNC_STAGES-1];
  assign in1 = sync1_q[SYNC_STAGES-1];

  // prev_q resets to 0, so a level already high at deassertion still yields one edge.
  assign edge_set = {in1[0], in0[0]} & ~prev_q;
  assign edge_clr = (wr_en && sel == R_EDGE) ? datain[1:0] : 2'b00;
  assign edge_d   = (edge_q & ~edge_clr) | edge_set;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_en && sel == R_CNT) begin
      cnt_d = datain;
    end else if (cnt_clr_q) begin
      cnt_d = 32'h0;
    end else if (cnt_en_q) begin
      cnt_d = cnt_q + 32'h1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0_q <= '0;
      sync1_q <= '0;
      prev_q  <= 2'b00;
      edge_q  <= 2'b00;
    end else begin
      sync0_q <= {sync0_q[SYNC_STAGES-2:0], in_port0};
      sync1_q <= {sync1_q[SYNC_STAGES-2:0], in_port1};
      prev_q  <= {in1[0], in0[0]};
      edge_q  <= edge_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out0_q    <= 32'h0;
      out1_q    <= 32'h0;
      out2_q    <= 32'h0;
      cnt_q     <= 32'h0;
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cnt_clr_q <= 1'b0;
      if (wr_en) begin
        case (sel)
          R_OUT0: out0_q <= datain;
          R_OUT1: out1_q <= datain;
          R_OUT2: out2_q <= datain;
          R_CTRL: begin
            cnt_en_q  <= datain[0];
            cnt_clr_q <= datain[1];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dataout = 32'h0;
    if (io_hit) begin
      case (sel)
        R_OUT0:  dataout = out0_q;
        R_OUT1:  dataout = out1_q;
        R_OUT2:  dataout = out2_q;
        R_IN0:   dataout = in0;
        R_IN1:   dataout = in1;
        R_EDGE:  dataout = {30'h0, edge_q};
        R_CNT:   dataout = cnt_q;
        R_CTRL:  dataout = {30'h0, cnt_clr_q, cnt_en_q};
        default: dataout = 32'h0;
      endcase
    end
  end

  assign out_port0 = out0_q;
  assign out_port1 = out1_q;
  assign out_port2 = out2_q;

endmodule

// File: tb/tb_sc_io_port.sv
// tb/tb_sc_io_port.sv - scoreboard bench for sc_io_port with directed vectors.
module tb_sc_io_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] datain = 32'h0;
  logic        we = 1'b0;
  logic [31:0] in_port0 = 32'h0;
  logic [31:0] in_port1 = 32'h0;
  logic [31:0] dataout;
  logic        io_hit;
  logic [31:0] out_port0, out_port1, out_port2;

  sc_io_port #(.IO_BASE(32'h00000080), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .addr(addr), .datain(datain), .we(we),
    .in_port0(in_port0), .in_port1(in_port1), .dataout(dataout), .io_hit(io_hit),
    .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2)
  );

  always #10 clock = ~clock;

  localparam int S_DOUT = 0, S_HIT = 1, S_OP0 = 2, S_OP1 = 3, S_OP2 = 4;

  typedef struct {
    string       name;
    int          src;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event kick, done;

  function automatic logic [31:0] observe(input int s);
    case (s)
      S_DOUT:  return dataout;
      S_HIT:   return {31'h0, io_hit};
      S_OP0:   return out_port0;
      S_OP1:   return out_port1;
      default: return out_port2;
    endcase
  endfunction

  // Monitor: drains every pending expectation on the falling edge or on demand.
  initial begin
    forever begin
      @(negedge clock or kick);
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] act;
        e = q.pop_front();
        act = observe(e.src);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
      ->done;
    end
  end

  task automatic push(input string n, input int s, input logic [31:0] e);
    exp_t x;
    x.name = n;
    x.src  = s;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic check_now();
    ->kick;
    @(done);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clock); #1;
    addr = a; datain = d; we = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    @(posedge clock); #1;
    addr = a; we = 1'b0;
    push(n, S_DOUT, e);
  endtask

  task automatic idle();
    @(posedge clock); #1;
    we = 1'b0;
  endtask

  initial begin
    #2;
    addr = 32'h80;
    #1;
    push("rst_dout", S_DOUT, 32'h0);
    push("rst_hit", S_HIT, 32'h1);
    push("rst_op0", S_OP0, 32'h0);
    push("rst_op1", S_OP1, 32'h0);
    push("rst_op2", S_OP2, 32'h0);
    check_now();
    @(negedge clock); #1;
    reset = 1'b0;

    // Output registers, aliasing and out-of-window stores
    wr(32'h80, 32'h11111111);
    wr(32'h88, 32'h22222222);
    wr(32'h84, 32'hDEADBEEF);
    rd(32'h84, 32'hDEADBEEF, "out1_rb");
    push("out1_port", S_OP1, 32'hDEADBEEF);
    rd(32'h87, 32'hDEADBEEF, "out1_alias");
    wr(32'h40, 32'h12345678);
    push("miss_hit", S_HIT, 32'h0);
    push("miss_dout", S_DOUT, 32'h0);
    idle();
    push("miss_op0", S_OP0, 32'h11111111);
    push("miss_op1", S_OP1, 32'hDEADBEEF);
    push("miss_op2", S_OP2, 32'h22222222);
    rd(32'hA0, 32'h0, "above_window");
    push("above_hit", S_HIT, 32'h0);

    // Input synchronizer latency and edge flag
    rd(32'h8C, 32'h0, "in0_pre");
    in_port0 = 32'h0000A5A5;
    rd(32'h8C, 32'h0, "in0_edge1");
    rd(32'h8C, 32'h0000A5A5, "in0_edge2");
    rd(32'h94, 32'h1, "edge0_set");
    wr(32'h8C, 32'hFFFFFFFF);
    rd(32'h8C, 32'h0000A5A5, "in0_ro");
    wr(32'h94, 32'h0);
    rd(32'h94, 32'h1, "edge_w0_keep");
    wr(32'h94, 32'h1);

    // W1C racing a new edge on port 1: set wins
    idle();
    in_port1 = 32'h1;
    idle();
    wr(32'h94, 32'h2);
    rd(32'h94, 32'h2, "edge_race");
    wr(32'h94, 32'h2);
    rd(32'h94, 32'h0, "edge_cleared");
    rd(32'h90, 32'h1, "in1_rb");
    in_port0 = 32'h0;

    // Counter wrap, then write/clear priority
    wr(32'h98, 32'hFFFFFFFE);
    wr(32'h9C, 32'h1);
    rd(32'h98, 32'hFFFFFFFE, "cnt_seq0");
    rd(32'h98, 32'hFFFFFFFF, "cnt_seq1");
    rd(32'h98, 32'h0, "cnt_wrap");
    rd(32'h98, 32'h1, "cnt_seq3");
    wr(32'h98, 32'h10);
    wr(32'h9C, 32'h3);
    rd(32'h98, 32'h11, "cnt_clr_pending");
    rd(32'h98, 32'h0, "cnt_cleared");
    rd(32'h9C, 32'h1, "ctrl_selfclr");
    rd(32'h98, 32'h2, "cnt_resume");

    // Asynchronous reset between clock edges
    wr(32'h9C, 32'h0);
    in_port0 = 32'h1;
    wr(32'h98, 32'h55);
    wr(32'h88, 32'h7);
    idle();
    rd(32'h94, 32'h1, "edge_pre_rst");
    rd(32'h98, 32'h55, "cnt_pre_rst");
    push("op2_pre_rst", S_OP2, 32'h7);
    @(negedge clock); #1;
    reset = 1'b1;
    addr = 32'h98;
    #1;
    push("rst_cnt", S_DOUT, 32'h0);
    push("rst_op2", S_OP2, 32'h0);
    check_now();
    addr = 32'h88;
    #1;
    push("rst_out2", S_DOUT, 32'h0);
    check_now();
    addr = 32'h94;
    #1;
    push("rst_edge", S_DOUT, 32'h0);
    check_now();
    reset = 1'b0;
    rd(32'h94, 32'h0, "edge_rst_e1");
    rd(32'h94, 32'h0, "edge_rst_e2");
    rd(32'h94, 32'h3, "edge_after_rst");
    rd(32'h98, 32'h0, "cnt_idle_rst");
    wr(32'h9C, 32'h1);
    rd(32'h98, 32'h0, "cnt_ctrl_edge");
    rd(32'h98, 32'h1, "cnt_restart");

    idle();
    idle();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
